// File: rtl/proc_run_ctrl_pkg.sv
// proc_run_ctrl_pkg
//   Shared definitions for the run/halt/step sequencer and the processor
//   decoder: host command op codes, sequencer state encoding, halt cause
//   codes and the default HALT opcode value.
package proc_run_ctrl_pkg;

  // Host command op codes carried on cmd_op (values 6-7 are reserved)
  typedef enum logic [2:0] {
    CMD_RUN     = 3'd0,
    CMD_HALT    = 3'd1,
    CMD_STEP    = 3'd2,
    CMD_SET_BP  = 3'd3,
    CMD_CLR_BP  = 3'd4,
    CMD_CLR_CNT = 3'd5
  } cmd_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } run_state_e;

  // Reason for the most recent halt, reported on halt_cause
  typedef enum logic [2:0] {
    CAUSE_RESET     = 3'd0,
    CAUSE_HOST      = 3'd1,
    CAUSE_BREAK     = 3'd2,
    CAUSE_HALT_INSN = 3'd3,
    CAUSE_STEP_DONE = 3'd4
  } halt_cause_e;

  // Opcode that stops execution; the processor decoder uses the same value
  localparam logic [3:0] HALT_OPCODE_DEFAULT = 4'b1111;

endpackage

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl
//   Run/halt/step sequencer for the 16-bit RISC processor. Produces the
//   per-cycle execute enable (cpu_en) that qualifies every PC update and
//   register/memory write in the datapath. A host command port selects run,
//   halt or N-step execution and manages a single PC breakpoint. Execution
//   also stops on a HALT opcode. Reports halted status, the halt cause and a
//   saturating count of executed instructions.
//
// Ports
//   clk          in   1      system clock, all state on rising edge
//   rst          in   1      synchronous active-high reset
//   cmd_valid    in   1      host command present
//   cmd_op       in   3      host command op code (cmd_op_e)
//   cmd_arg      in   PC_W   STEP count / SET_BP address
//   cmd_ready    out  1      command accepted when cmd_valid & cmd_ready
//   pc           in   PC_W   PC of the instruction about to execute
//   opcode       in   4      opcode of the instruction at pc
//   cpu_en       out  1      datapath commits the instruction at pc this edge
//   halted       out  1      sequencer is in the HALTED state
//   halt_cause   out  3      reason for the last halt (halt_cause_e)
//   instr_count  out  CNT_W  number of committed instructions, saturating
module proc_run_ctrl
  import proc_run_ctrl_pkg::*;
#(
  parameter int         PC_W        = 16,
  parameter int         CNT_W       = 32,
  parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  input  logic [PC_W-1:0]  cmd_arg,
  output logic             cmd_ready,
  input  logic [PC_W-1:0]  pc,
  input  logic [3:0]       opcode,
  output logic             cpu_en,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] instr_count
);

  run_state_e       state_q, state_d;
  halt_cause_e      cause_q, cause_d;
  logic [PC_W-1:0]  step_q, step_d;
  logic [PC_W-1:0]  bp_addr_q, bp_addr_d;
  logic             bp_en_q, bp_en_d;
  logic             skip_q, skip_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_clr;

  logic is_halt_op;
  logic bp_hit;
  logic host_halt;

  assign is_halt_op = (opcode == HALT_OPCODE);

  // skip_bp masks the breakpoint on the first RUN cycle so that resuming
  // from a breakpoint address executes that instruction once.
  assign bp_hit = bp_en_q & (pc == bp_addr_q) & ~skip_q;

  // Only HALT can be accepted while executing; everything else stalls.
  assign cmd_ready = (state_q == ST_HALTED) | (cmd_op == CMD_HALT);
  assign host_halt = cmd_valid & (cmd_op == CMD_HALT);

  assign halted      = (state_q == ST_HALTED);
  assign halt_cause  = cause_q;
  assign instr_count = cnt_q;

  // Zero-latency execute enable from the registered state and the current
  // instruction. Reset must kill the enable in the same cycle it is asserted.
  always_comb begin
    cpu_en = 1'b0;
    unique case (state_q)
      ST_RUN:  cpu_en = ~rst & ~is_halt_op & ~bp_hit;
      ST_STEP: cpu_en = ~rst & ~is_halt_op;
      default: cpu_en = 1'b0;
    endcase
  end

  // Next-state logic: command handling in HALTED, stop conditions in RUN and
  // STEP. Blocked cycles (HALT opcode, breakpoint) take priority over a host
  // HALT; a host HALT cycle still commits its instruction.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    step_d    = step_q;
    bp_addr_d = bp_addr_q;
    bp_en_d   = bp_en_q;
    skip_d    = skip_q;
    cnt_clr   = 1'b0;

    unique case (state_q)
      ST_HALTED: begin
        if (cmd_valid) begin
          case (cmd_op)
            CMD_RUN: begin
              state_d = ST_RUN;
              skip_d  = 1'b1;
            end
            CMD_STEP: begin
              state_d = ST_STEP;
              step_d  = (cmd_arg == '0) ? PC_W'(1) : cmd_arg;
            end
            CMD_SET_BP: begin
              bp_addr_d = cmd_arg;
              bp_en_d   = 1'b1;
            end
            CMD_CLR_BP:  bp_en_d = 1'b0;
            CMD_CLR_CNT: cnt_clr = 1'b1;
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        skip_d = 1'b0;
        if (is_halt_op) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HALT_INSN;
        end else if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BREAK;
        end else if (host_halt) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HOST;
        end
      end

      ST_STEP: begin
        // A HALT opcode blocks the step without consuming it.
        if (is_halt_op) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HALT_INSN;
        end else begin
          step_d = step_q - PC_W'(1);
          if (host_halt) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_HOST;
          end else if (step_q == PC_W'(1)) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_STEP_DONE;
          end
        end
      end

      default: state_d = ST_HALTED;
    endcase
  end

  // Saturating instruction counter; clears only via CLR_CNT while halted,
  // when cpu_en is always 0, so clear and increment never collide.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cpu_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HALTED;
      cause_q   <= CAUSE_RESET;
      step_q    <= '0;
      bp_addr_q <= '0;
      bp_en_q   <= 1'b0;
      skip_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      step_q    <= step_d;
      bp_addr_q <= bp_addr_d;
      bp_en_q   <= bp_en_d;
      skip_q    <= skip_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl
//   Self-checking bench for proc_run_ctrl. A small program memory and PC
//   register stand in for the datapath; the PC advances on cycles the
//   reference model says commit. Directed scenarios come first, followed by
//   a randomized phase, all checked cycle by cycle against the model.
module tb_proc_run_ctrl;

  localparam int     PC_W    = 16;
  localparam int     CNT_W   = 12;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  localparam int HALTM = 0;
  localparam int RUNM  = 1;
  localparam int STEPM = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic [2:0]       cmd_op;
  logic [PC_W-1:0]  cmd_arg;
  logic             cmd_ready;
  logic [PC_W-1:0]  pc;
  logic [3:0]       opcode;
  logic             cpu_en;
  logic             halted;
  logic [2:0]       halt_cause;
  logic [CNT_W-1:0] instr_count;

  logic [3:0] prog [0:255];

  int checks   = 0;
  int failures = 0;

  // Reference model: mode, cause, counters and breakpoint as plain numbers
  int     m_mode;
  int     m_cause;
  longint m_cnt;
  int     m_bp_en;
  int     m_bp_addr;
  int     m_steps;
  int     m_skip;

  always #5 clk = ~clk;

  assign opcode = prog[pc[7:0]];

  proc_run_ctrl #(
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .cmd_ready   (cmd_ready),
    .pc          (pc),
    .opcode      (opcode),
    .cpu_en      (cpu_en),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .instr_count (instr_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic stop_with(input int cause);
    m_mode  = HALTM;
    m_cause = cause;
  endtask

  // One clock: check the combinational outputs against the model before the
  // edge, advance model and PC just after it, check registered outputs at
  // the following falling edge. Inputs are set by the caller at a falling edge.
  task automatic do_cycle();
    logic en, rdy, acc, halt_op, hit;
    #1;
    halt_op = (opcode == 4'hF);
    hit     = (m_bp_en != 0) && (int'(pc) == m_bp_addr) && (m_skip == 0);
    en      = !rst && (((m_mode == RUNM) && !halt_op && !hit) ||
                       ((m_mode == STEPM) && !halt_op));
    rdy     = (m_mode == HALTM) || (cmd_op == 3'd1);
    acc     = cmd_valid && rdy;
    chk("cpu_en", cpu_en, en);
    chk("cmd_ready", cmd_ready, rdy);
    @(posedge clk);
    #1;
    if (rst) begin
      m_mode = HALTM; m_cause = 0; m_cnt = 0;
      m_bp_en = 0; m_bp_addr = 0; m_steps = 0; m_skip = 0;
      pc = '0;
    end else begin
      if (en) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        pc = pc + 1'b1;
      end
      case (m_mode)
        HALTM: if (acc) begin
          case (int'(cmd_op))
            0: begin m_mode = RUNM; m_skip = 1; end
            2: begin m_steps = (cmd_arg == 0) ? 1 : int'(cmd_arg); m_mode = STEPM; end
            3: begin m_bp_addr = int'(cmd_arg); m_bp_en = 1; end
            4: m_bp_en = 0;
            5: m_cnt = 0;
            default: ;
          endcase
        end
        RUNM: begin
          m_skip = 0;
          if (halt_op) stop_with(3);
          else if (hit) stop_with(2);
          else if (acc && cmd_op == 3'd1) stop_with(1);
        end
        default: begin
          if (halt_op) stop_with(3);
          else begin
            m_steps--;
            if (acc && cmd_op == 3'd1) stop_with(1);
            else if (m_steps == 0) stop_with(4);
          end
        end
      endcase
    end
    @(negedge clk);
    chk("halted", halted, (m_mode == HALTM));
    chk("halt_cause", halt_cause, m_cause);
    chk("instr_count", instr_count, m_cnt);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [PC_W-1:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    do_cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    do_cycle();
    rst = 1'b0;
  endtask

  task automatic run_until_halt(input int limit);
    for (int i = 0; i < limit && m_mode != HALTM; i++) do_cycle();
    chk("halt_within_bound", halted, 1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic exp_halted,
                             input logic [2:0] exp_cause, input longint exp_cnt);
    chk({tag, "_halted"}, halted, exp_halted);
    chk({tag, "_cause"}, halt_cause, exp_cause);
    chk({tag, "_count"}, instr_count, exp_cnt);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd7; cmd_arg = '0; pc = '0;
    m_mode = HALTM; m_cause = 0; m_cnt = 0;
    m_bp_en = 0; m_bp_addr = 0; m_steps = 0; m_skip = 0;
    for (int i = 0; i < 256; i++) prog[i] = 4'h0;
    prog[16] = 4'hF;
    @(negedge clk);

    // 1: run from reset into a HALT opcode at 0x0010
    do_reset();
    do_reset();
    checkOutput("reset", 1'b1, 3'd0, 0);
    applyStimulus(3'd0, '0);
    run_until_halt(100);
    checkOutput("t1", 1'b1, 3'd3, 16);

    // 2: breakpoint at 0x0008, then resume past it
    do_reset();
    applyStimulus(3'd3, 16'h0008);
    applyStimulus(3'd0, '0);
    run_until_halt(100);
    checkOutput("t2_break", 1'b1, 3'd2, 8);
    applyStimulus(3'd0, '0);
    run_until_halt(100);
    checkOutput("t2_resume", 1'b1, 3'd3, 16);

    // 3: step 3 then step 0 (single step)
    do_reset();
    applyStimulus(3'd2, 16'd3);
    run_until_halt(20);
    checkOutput("t3_step3", 1'b1, 3'd4, 3);
    applyStimulus(3'd2, 16'd0);
    run_until_halt(20);
    checkOutput("t3_step0", 1'b1, 3'd4, 4);

    // 4: RUN stalls while running; host HALT commits its cycle
    applyStimulus(3'd0, '0);
    applyStimulus(3'd0, '0);
    applyStimulus(3'd1, '0);
    checkOutput("t4_host", 1'b1, 3'd1, 6);

    // 5: reset in the middle of a 5-step sequence with a breakpoint armed
    applyStimulus(3'd3, 16'h0002);
    applyStimulus(3'd2, 16'd5);
    rst = 1'b1;
    #1;
    chk("t5_en_in_reset", cpu_en, 1'b0);
    do_cycle();
    rst = 1'b0;
    checkOutput("t5_reset", 1'b1, 3'd0, 0);
    applyStimulus(3'd0, '0);
    run_until_halt(100);
    checkOutput("t5_bp_cleared", 1'b1, 3'd3, 16);

    // 6: counter saturation and CLR_CNT
    do_reset();
    prog[16] = 4'h0;
    applyStimulus(3'd0, '0);
    for (int i = 0; i < int'(CNT_MAX) + 4; i++) do_cycle();
    chk("t6_saturated", instr_count, CNT_MAX);
    applyStimulus(3'd1, '0);
    checkOutput("t6_halt", 1'b1, 3'd1, CNT_MAX);
    applyStimulus(3'd5, '0);
    checkOutput("t6_clr", 1'b1, 3'd1, 0);

    // Randomized phase
    for (int i = 0; i < 256; i++)
      prog[i] = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_arg   = (cmd_op == 3'd3) ? PC_W'($urandom_range(0, 255))
                                   : PC_W'($urandom_range(0, 12));
      if (m_mode == HALTM && $urandom_range(0, 3) == 0)
        pc = PC_W'($urandom_range(0, 255));
      do_cycle();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
